// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and sizing for the instruction-memory load controller.
package imem_load_ctrl_pkg;

  localparam int IMEM_DEPTH = 2048;
  localparam int INSTR_W    = 17;
  localparam int IMEM_IDX_W = $clog2(IMEM_DEPTH);
  localparam int CPU_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    ERR
  } imem_ld_state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of loader, fetch and IM-port signals around the load controller.
interface imem_load_ctrl_if;
  import imem_load_ctrl_pkg::*;

  logic                  start_load;
  logic                  ld_valid;
  logic [INSTR_W-1:0]    ld_data;
  logic                  ld_last;
  logic                  ld_ready;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic                  cpu_rd_en;
  logic                  cpu_stall;
  logic                  mem_rd_en;
  logic [CPU_ADDR_W-1:0] mem_rd_addr;
  logic                  mem_we;
  logic [IMEM_IDX_W-1:0] mem_wr_addr;
  logic [INSTR_W-1:0]    mem_wr_data;
  logic                  load_done;
  logic                  load_err;
  logic [IMEM_IDX_W:0]   word_count;

  // Controller side: consumes loader/fetch requests, drives the IM port and status.
  modport master (
    input  start_load, ld_valid, ld_data, ld_last, cpu_addr, cpu_rd_en,
    output ld_ready, cpu_stall, mem_rd_en, mem_rd_addr, mem_we, mem_wr_addr,
           mem_wr_data, load_done, load_err, word_count
  );

  // Environment side: loader, CPU fetch stage and IM array.
  modport slave (
    output start_load, ld_valid, ld_data, ld_last, cpu_addr, cpu_rd_en,
    input  ld_ready, cpu_stall, mem_rd_en, mem_rd_addr, mem_we, mem_wr_addr,
           mem_wr_data, load_done, load_err, word_count
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams loader words into sequential IM
// addresses while the CPU is stalled, then hands the read port to fetch.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  imem_load_ctrl_if.master bus
);

  localparam logic [IMEM_IDX_W-1:0] PTR_LAST = IMEM_IDX_W'(IMEM_DEPTH - 1);

  imem_ld_state_t        state, state_nxt;
  logic [IMEM_IDX_W-1:0] wr_ptr;
  logic [IMEM_IDX_W:0]   word_cnt;
  logic                  we_q;
  logic [IMEM_IDX_W-1:0] wr_addr_q;
  logic [INSTR_W-1:0]    wr_data_q;
  logic                  done_q;
  logic                  err_q;
  logic                  accept;
  logic                  restart;

  assign accept  = bus.ld_valid && (state == LOAD);
  assign restart = bus.start_load && (state inside {IDLE, RUN, ERR});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and the combinational handshake/stall/read-enable outputs.
  always_comb begin
    state_nxt     = state;
    bus.ld_ready  = 1'b0;
    bus.cpu_stall = 1'b1;
    bus.mem_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_load) state_nxt = LOAD;
      end
      LOAD: begin
        bus.ld_ready = 1'b1;
        if (accept) begin
          if (bus.ld_last)             state_nxt = DRAIN;
          else if (wr_ptr == PTR_LAST) state_nxt = ERR;
        end
      end
      DRAIN: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.start_load) begin
          state_nxt = LOAD;
        end else begin
          bus.cpu_stall = 1'b0;
          bus.mem_rd_en = bus.cpu_rd_en;
        end
      end
      ERR: begin
        if (bus.start_load) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write port, pointers, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      word_cnt  <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (restart) begin
        wr_ptr   <= '0;
        word_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (accept) begin
        we_q      <= 1'b1;
        wr_addr_q <= wr_ptr;
        wr_data_q <= bus.ld_data;
        wr_ptr    <= wr_ptr + 1'b1;
        word_cnt  <= word_cnt + 1'b1;
        if (!bus.ld_last && (wr_ptr == PTR_LAST)) err_q <= 1'b1;
      end
      if (state == DRAIN) done_q <= 1'b1;
    end
  end

  assign bus.mem_rd_addr = bus.cpu_addr;
  assign bus.mem_we      = we_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.word_count  = word_cnt;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with an IM array model and a
// program-level reference (expected word list, write order, done timing).
module tb_imem_load_ctrl;
  import imem_load_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_load_ctrl_if ifc();

  imem_load_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  logic [INSTR_W-1:0] imArray  [IMEM_DEPTH];
  logic [INSTR_W-1:0] progWords[IMEM_DEPTH];
  logic [INSTR_W-1:0] imRdData;
  int wrAddrLog[$];
  int wrDataLog[$];
  int cycleNum = 0;
  int lastAcceptCycle = 0;
  int doneCycle = 0;
  int donePulses = 0;
  int assertCount = 0;
  int failCount = 0;

  // Free-running cycle counter for latency measurements.
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // IM array model plus write/accept/done monitor, all on the negedge.
  always @(negedge clk) begin
    if (ifc.mem_we) begin
      imArray[ifc.mem_wr_addr] <= ifc.mem_wr_data;
      wrAddrLog.push_back(int'(ifc.mem_wr_addr));
      wrDataLog.push_back(int'(ifc.mem_wr_data));
    end
    if (ifc.mem_rd_en) imRdData <= imArray[ifc.mem_rd_addr[IMEM_IDX_W-1:0]];
    if (ifc.ld_valid && ifc.ld_ready && ifc.ld_last) lastAcceptCycle = cycleNum;
    if (ifc.load_done) begin
      donePulses++;
      doneCycle = cycleNum;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, return at the negedge.
  task automatic applyStimulus(input logic start, input logic valid,
                               input logic [INSTR_W-1:0] data, input logic last,
                               input logic rdEn, input logic [CPU_ADDR_W-1:0] addr);
    @(posedge clk);
    #1;
    ifc.start_load = start;
    ifc.ld_valid   = valid;
    ifc.ld_data    = data;
    ifc.ld_last    = last;
    ifc.cpu_rd_en  = rdEn;
    ifc.cpu_addr   = addr;
    @(negedge clk);
  endtask

  // Start a load and stream progWords[0..n-1], with random valid gaps.
  task automatic loadProgram(input int n, input bit withLast, input int gapPct);
    int i;
    int guard;
    logic v;
    wrAddrLog.delete();
    wrDataLog.delete();
    donePulses = 0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    i = 0;
    guard = 0;
    while (i < n && guard < 3 * n + 50) begin
      v = ($urandom_range(99) >= gapPct);
      applyStimulus(1'b0, v, progWords[i], withLast && (i == n - 1), 1'b0, '0);
      if (v && ifc.ld_ready) i++;
      guard++;
    end
    checkOutput("load_accepts", i, n);
    repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // Compare the observed write stream and status against the expected program.
  task automatic verifyLoad(input int n, input bit withLast);
    int bad;
    bad = 0;
    checkOutput("wr_count", wrAddrLog.size(), n);
    for (int i = 0; i < wrAddrLog.size(); i++)
      if (wrAddrLog[i] != i || wrDataLog[i] != int'(progWords[i])) bad++;
    checkOutput("wr_seq_bad", bad, 0);
    checkOutput("word_count", ifc.word_count, n);
    checkOutput("ld_ready_after", ifc.ld_ready, 0);
    if (withLast) begin
      checkOutput("done_pulses", donePulses, 1);
      checkOutput("done_latency", doneCycle - lastAcceptCycle, 2);
      checkOutput("stall_run", ifc.cpu_stall, 0);
      checkOutput("load_err_run", ifc.load_err, 0);
    end else begin
      checkOutput("done_pulses_err", donePulses, 0);
      checkOutput("load_err_set", ifc.load_err, 1);
      checkOutput("stall_err", ifc.cpu_stall, 1);
    end
  endtask

  initial begin
    int n;
    int a;
    ifc.start_load = 1'b0;
    ifc.ld_valid   = 1'b0;
    ifc.ld_data    = '0;
    ifc.ld_last    = 1'b0;
    ifc.cpu_rd_en  = 1'b0;
    ifc.cpu_addr   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_stall", ifc.cpu_stall, 1);
    checkOutput("rst_ld_ready", ifc.ld_ready, 0);
    checkOutput("rst_mem_we", ifc.mem_we, 0);
    checkOutput("rst_load_err", ifc.load_err, 0);
    checkOutput("rst_word_count", ifc.word_count, 0);
    checkOutput("rst_load_done", ifc.load_done, 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd3);
    checkOutput("idle_rd_en", ifc.mem_rd_en, 0);

    $display("[TB] directed four-word load");
    for (int i = 0; i < 4; i++) progWords[i] = INSTR_W'(17'h1_0001 + i);
    loadProgram(4, 1'b1, 0);
    verifyLoad(4, 1'b1);

    $display("[TB] fetch read in RUN");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'd2);
    checkOutput("run_rd_en", ifc.mem_rd_en, 1);
    checkOutput("run_rd_addr", ifc.mem_rd_addr, 2);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("run_rd_data", imRdData, 17'h1_0003);
    checkOutput("run_rd_en_low", ifc.mem_rd_en, 0);

    $display("[TB] randomized loads with gaps");
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) progWords[i] = INSTR_W'($urandom);
      loadProgram(n, 1'b1, 40);
      verifyLoad(n, 1'b1);
      for (int k = 0; k < 6; k++) begin
        a = $urandom_range(0, n - 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, CPU_ADDR_W'(a));
        checkOutput("rnd_rd_addr", ifc.mem_rd_addr, a);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("rnd_rd_data", imRdData, progWords[a]);
      end
      a = 16'hF000 | $urandom_range(0, 16'h0FFF);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, CPU_ADDR_W'(a));
      checkOutput("oob_rd_addr", ifc.mem_rd_addr, a);
      checkOutput("oob_rd_en", ifc.mem_rd_en, 1);
    end

    $display("[TB] overflow without last word");
    for (int i = 0; i < IMEM_DEPTH; i++) progWords[i] = INSTR_W'($urandom);
    loadProgram(IMEM_DEPTH, 1'b0, 0);
    verifyLoad(IMEM_DEPTH, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 17'h1_5555, 1'b0, 1'b1, 16'd5);
      checkOutput("err_ld_ready", ifc.ld_ready, 0);
      checkOutput("err_rd_en", ifc.mem_rd_en, 0);
      checkOutput("err_load_err", ifc.load_err, 1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("err_no_extra_wr", wrAddrLog.size(), IMEM_DEPTH);
    progWords[0] = INSTR_W'($urandom);
    loadProgram(1, 1'b1, 0);
    verifyLoad(1, 1'b1);

    $display("[TB] start_load beats fetch, then reset mid-load");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 16'd7);
    checkOutput("restart_rd_en", ifc.mem_rd_en, 0);
    checkOutput("restart_stall", ifc.cpu_stall, 1);
    wrAddrLog.delete();
    wrDataLog.delete();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, INSTR_W'(k + 9), 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ifc.ld_data = 17'h0_00AA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.ld_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_mem_we", ifc.mem_we, 0);
    checkOutput("mid_rst_word_count", ifc.word_count, 0);
    checkOutput("mid_rst_stall", ifc.cpu_stall, 1);
    checkOutput("mid_rst_ld_ready", ifc.ld_ready, 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("mid_rst_mem_we2", ifc.mem_we, 0);
    checkOutput("mid_rst_writes", wrAddrLog.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
